ha: RTL and testbench

- Registered 1-bit half adder: sum = a XOR b, carry = a AND b, captured on a single clock with a valid qualifier.
- Includes an optional saturating counter of carry-generating operations, used as a lightweight activity monitor.
- Leaf arithmetic cell inside larger adder/ALU datapaths, and a directed bring-up target.

---
 rtl/ha.sv | 54 +++++
 tb/tb_ha.sv | 131 +++++++++++++
 2 files changed

// File: rtl/ha.sv
// Registered 1-bit half adder with valid qualifier and an optional saturating
// carry-event counter, enabled by defining HA_CARRY_CNT_EN.
module ha #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             in_valid,
  input  logic             cnt_clr,
  output logic             suma,
  output logic             carry,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_cnt
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      suma      <= 1'b0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      // Results hold while idle so downstream never sees a spurious zero.
      if (in_valid) begin
        suma  <= a ^ b;
        carry <= a & b;
      end
    end
  end

`ifdef HA_CARRY_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_cnt <= '0;
    end else if (cnt_clr) begin
      carry_cnt <= '0;
    end else if (in_valid && a && b && (carry_cnt != CNT_MAX)) begin
      carry_cnt <= carry_cnt + CNT_W'(1'b1);
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign carry_cnt      = '0;
`endif

endmodule

// File: tb/tb_ha.sv
// Directed bench for ha: reset, truth table, hold, counter clear/saturation
// (8-bit and 2-bit instances) and asynchronous reset mid-stream.
module tb_ha;

`ifdef HA_CARRY_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, a, b, in_valid, cnt_clr;
  logic       suma, carry, out_valid;
  logic       suma_s, carry_s, out_valid_s;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int vectors     = 0;
  int miscompares = 0;

  always #10 clk = ~clk;

  ha #(.CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
    .cnt_clr(cnt_clr), .suma(suma), .carry(carry), .out_valid(out_valid),
    .carry_cnt(cnt8)
  );

  ha #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
    .cnt_clr(cnt_clr), .suma(suma_s), .carry(carry_s), .out_valid(out_valid_s),
    .carry_cnt(cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic s, input logic c, input logic v);
    check({tag, ".suma"},      {31'd0, suma},      {31'd0, s});
    check({tag, ".carry"},     {31'd0, carry},     {31'd0, c});
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
  endtask

  task automatic check_cnt(input string tag, input int n8, input int n2);
    check({tag, ".cnt8"}, {24'd0, cnt8}, CNT_ON ? n8 : 0);
    check({tag, ".cnt2"}, {30'd0, cnt2}, CNT_ON ? n2 : 0);
  endtask

  // Drive inputs just after an edge, let one rising edge pass, sample 1 ns later.
  task automatic step(input logic v, input logic ia, input logic ib, input logic clr);
    in_valid = v;
    a        = ia;
    b        = ib;
    cnt_clr  = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; a = 1'b1; b = 1'b1; cnt_clr = 1'b0;

    // Reset held with active operands on the inputs.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_out("reset", 1'b0, 1'b0, 1'b0);
      check_cnt("reset", 0, 0);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;

    // Truth table, one cycle latency.
    step(1'b1, 1'b0, 1'b0, 1'b0); check_out("tt00", 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0); check_out("tt01", 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0); check_out("tt10", 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0); check_out("tt11", 1'b0, 1'b1, 1'b1);
    check_cnt("tt11", 1, 1);

    // Hold on idle, including unknown operands.
    step(1'b1, 1'b1, 1'b0, 1'b0); check_out("hold_load", 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0); check_out("hold_idle", 1'b1, 1'b0, 1'b0);
    check_cnt("hold_idle", 1, 1);
    step(1'b0, 1'bx, 1'bx, 1'b0); check_out("hold_x", 1'b1, 1'b0, 1'b0);
    check_cnt("hold_x", 1, 1);

    // Clear, then count six carry events; the 2-bit instance saturates at 3.
    step(1'b0, 1'b0, 1'b0, 1'b1); check_cnt("clr_idle", 0, 0);
    check_out("clr_idle", 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check_cnt($sformatf("count%0d", i), i, (i > 3) ? 3 : i);
    end
    check_out("count6", 1'b0, 1'b1, 1'b1);

    // Clear beats a simultaneous increment and leaves the datapath alone.
    step(1'b1, 1'b1, 1'b1, 1'b1); check_cnt("clr_inc", 0, 0);
    check_out("clr_inc", 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0); check_cnt("after_clr", 0, 0);
    check_out("after_clr", 1'b1, 1'b0, 1'b1);

    // Asynchronous reset between edges after a valid 11.
    step(1'b1, 1'b1, 1'b1, 1'b0); check_out("pre_areset", 1'b0, 1'b1, 1'b1);
    check_cnt("pre_areset", 1, 1);
    #4;
    rst_n = 1'b0;
    #1;
    check_out("areset_now", 1'b0, 1'b0, 1'b0);
    check_cnt("areset_now", 0, 0);
    @(posedge clk);
    #1;
    check_out("areset_edge", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b0); check_out("post_areset", 1'b0, 1'b0, 1'b0);
    check_cnt("post_areset", 0, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0); check_out("post_areset_op", 1'b1, 1'b0, 1'b1);

    // The saturation instance must track the same datapath results.
    check("sat_inst.suma",  {31'd0, suma_s},      32'd1);
    check("sat_inst.valid", {31'd0, out_valid_s}, 32'd1);
    check("sat_inst.carry", {31'd0, carry_s},     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
